// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALU/MD operations and the D->E control bundle shared by the decode controller
package ctrl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  typedef enum logic [4:0] {
    ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } alu_op_t;
  localparam logic [2:0] RES_ALU = 3'd0;
  localparam logic [2:0] RES_MEM = 3'd1;
  localparam logic [2:0] RES_PC4 = 3'd2;
  localparam logic [2:0] RES_IMM = 3'd3;
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       jump_reg;
    logic       branch;
    logic       alu_src;
    logic       src_a_pc;
    logic       illegal;
    logic [2:0] result_src;
    logic [2:0] funct3;
    alu_op_t    alu;
  } ctrl_bundle_t;
  localparam ctrl_bundle_t NOP_BUNDLE = '{
    reg_write: 1'b0, mem_write: 1'b0, jump: 1'b0, jump_reg: 1'b0, branch: 1'b0,
    alu_src: 1'b0, src_a_pc: 1'b0, illegal: 1'b0, result_src: RES_ALU, funct3: 3'd0, alu: ADD
  };
  // alt selects SUB/SRA over ADD/SRL (instruction bit 30)
  function automatic alu_op_t alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? SUB : ADD;
      3'd1:    return SLL;
      3'd2:    return SLT;
      3'd3:    return SLTU;
      3'd4:    return XOR;
      3'd5:    return alt ? SRA : SRL;
      3'd6:    return OR;
      default: return AND;
    endcase
  endfunction
  function automatic logic is_md(input alu_op_t a);
    return a >= MUL;
  endfunction
  function automatic logic is_div(input alu_op_t a);
    return a >= DIV;
  endfunction
endpackage

// File: rtl/md_sequencer.sv
// md_sequencer: times multi-cycle MUL/DIV ops held in E, raising busy until the result is due
module md_sequencer
  import ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic md_op,
  input  logic div_op,
  input  logic flush,
  output logic start,
  output logic busy,
  output logic done
);
  localparam int CW = $clog2(MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES) + 1;
  md_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, lat;
  assign lat = div_op ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  // cnt holds the BUSY cycles still to go after the current one, so DONE lands in the L-th E cycle
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    start = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: begin
        if (md_op && !flush) begin
          start = 1'b1;
          if (lat == CW'(1)) done = 1'b1;
          else begin
            busy = 1'b1;
            cnt_n = lat - CW'(3);
            state_n = (lat == CW'(2)) ? DONE : BUSY;
          end
        end
      end
      BUSY: begin
        busy = 1'b1;
        cnt_n = cnt - CW'(1);
        if (flush) state_n = IDLE;
        else if (cnt == '0) state_n = DONE;
      end
      DONE: begin
        done = !flush;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: rtl/pipelined_controller_m.sv
// pipelined_controller_m: RV32IM decode-stage controller with the D->E control register and MD sequencing
module pipelined_controller_m
  import ctrl_pkg::*;
#(
  parameter int ENABLE_M   = 1,
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 32,
  parameter int ALUCTRL_W  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          InstrD,
  input  logic                 StallE,
  input  logic                 FlushE,
  output logic [2:0]           ImmSrcD,
  output logic [2:0]           ResultSrcE,
  output logic                 RegWriteE,
  output logic                 MemWriteE,
  output logic                 JumpE,
  output logic                 jumpRegE,
  output logic                 BranchE,
  output logic                 ALUSrcE,
  output logic                 SrcAsrcE,
  output logic [2:0]           funct3E,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 IllegalE,
  output logic                 MdStartE,
  output logic                 MdBusyE,
  output logic                 MdDoneE
);
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic ok;
  logic unused_instr;
  ctrl_bundle_t d, e;
  assign op = InstrD[6:0];
  assign f3 = InstrD[14:12];
  assign f7 = InstrD[31:25];
  assign unused_instr = ^{InstrD[24:15], InstrD[11:7]};
  always_comb begin
    d = NOP_BUNDLE;
    d.funct3 = f3;
    ImmSrcD = IMM_I;
    ok = 1'b1;
    case (op)
      OP_R: begin
        d.reg_write = 1'b1;
        if (f7 == 7'h00) d.alu = alu_base(f3, 1'b0);
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) d.alu = alu_base(f3, 1'b1);
        else if (ENABLE_M != 0 && f7 == 7'h01) d.alu = alu_op_t'(5'(MUL) + {2'b00, f3});
        else ok = 1'b0;
      end
      OP_I: begin
        d.reg_write = 1'b1;
        d.alu_src = 1'b1;
        d.alu = alu_base(f3, f3 == 3'd5 && InstrD[30]);
        ok = (f3 == 3'd1) ? f7 == 7'h00 : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      end
      OP_LOAD: begin
        d.reg_write = 1'b1;
        d.alu_src = 1'b1;
        d.result_src = RES_MEM;
        ok = f3 != 3'd3 && f3 < 3'd6;
      end
      OP_STORE: begin
        ImmSrcD = IMM_S;
        d.mem_write = 1'b1;
        d.alu_src = 1'b1;
        ok = f3 <= 3'd2;
      end
      OP_BRANCH: begin
        ImmSrcD = IMM_B;
        d.branch = 1'b1;
        d.alu = SUB;
        ok = f3 != 3'd2 && f3 != 3'd3;
      end
      OP_JAL: begin
        ImmSrcD = IMM_J;
        d.jump = 1'b1;
        d.reg_write = 1'b1;
        d.result_src = RES_PC4;
      end
      OP_JALR: begin
        d.jump = 1'b1;
        d.jump_reg = 1'b1;
        d.reg_write = 1'b1;
        d.alu_src = 1'b1;
        d.result_src = RES_PC4;
        ok = f3 == 3'd0;
      end
      OP_LUI: begin
        ImmSrcD = IMM_U;
        d.reg_write = 1'b1;
        d.result_src = RES_IMM;
      end
      OP_AUIPC: begin
        ImmSrcD = IMM_U;
        d.reg_write = 1'b1;
        d.src_a_pc = 1'b1;
        d.alu_src = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      d = NOP_BUNDLE;
      d.illegal = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || FlushE) e <= NOP_BUNDLE;
    else if (!StallE) e <= d;
  end
  assign ResultSrcE = e.result_src;
  assign RegWriteE = e.reg_write;
  assign MemWriteE = e.mem_write;
  assign JumpE = e.jump;
  assign jumpRegE = e.jump_reg;
  assign BranchE = e.branch;
  assign ALUSrcE = e.alu_src;
  assign SrcAsrcE = e.src_a_pc;
  assign funct3E = e.funct3;
  assign ALUControlE = e.alu[ALUCTRL_W-1:0];
  assign IllegalE = e.illegal;
  md_sequencer #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_md (
    .clk(clk),
    .reset(reset),
    .md_op(is_md(e.alu)),
    .div_op(is_div(e.alu)),
    .flush(FlushE),
    .start(MdStartE),
    .busy(MdBusyE),
    .done(MdDoneE)
  );
endmodule
